// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types for the FU-to-scoreboard arbiter.
// Holds the result entry layout and the exception record carried with it.
package wb_arbiter_pkg;

    localparam int unsigned NR_WB_PORTS   = 4;
    localparam int unsigned TRANS_ID_BITS = 3;

    localparam logic [63:0] LOAD_PAGE_FAULT = 64'd13;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
        exception_t               ex;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i,
// wrapping modulo N. The grant is gated by en_i; idx_o is always valid.
module rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] idx_o
);

    always_comb begin
        int unsigned pos;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(ptr_i) + off;
            if (pos >= N) pos = pos - N;
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = PtrW'(pos);
            end
        end
        gnt_o[idx_o] = en_i & found;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the scoreboard writeback port between FUs,
// with a single registered output stage and flush support.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int unsigned NR_PORTS   = NR_WB_PORTS,
    parameter  int unsigned DATA_WIDTH = 64,
    localparam int unsigned PtrW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NR_PORTS-1:0] valid_i,
    output logic [NR_PORTS-1:0] ready_o,
    input  wb_entry_t           wb_i [NR_PORTS],
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output wb_entry_t           wb_o
);

    logic      valid_q, valid_d;
    wb_entry_t data_q, data_d;
    logic [PtrW-1:0] rr_q, rr_d;
    logic [PtrW-1:0] idx;
    logic            load;
    logic            xfer;

    assign load = (!valid_q || wb_ready_i) && !flush_i && !rst_i;

    rr_arbiter #(.N(NR_PORTS)) u_rr (
        .req_i (valid_i),
        .ptr_i (rr_q),
        .en_i  (load),
        .gnt_o (ready_o),
        .idx_o (idx)
    );

    assign xfer = |ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        rr_d    = rr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            data_d  = wb_i[idx];
            rr_d    = (idx == PtrW'(NR_PORTS - 1)) ? '0 : idx + 1'b1;
        end else if (wb_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_o       = data_q;

    a_width: assert property (@(posedge clk_i) DATA_WIDTH == 64);

    a_onehot: assert property (@(posedge clk_i) $onehot0(ready_o));

    a_rdy_vld: assert property (@(posedge clk_i) (ready_o & ~valid_i) == '0);

    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_q && !wb_ready_i && !flush_i) |=> $stable(wb_o));

endmodule
